// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: result-source and ALU encodings and the
// decoded control bundle carried from ID into EX.
package riscv_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       RegWrite;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic       ALUSrc;
        logic [1:0] ResultSrc;
        logic [2:0] ALUControl;
    } ctrl_t;

    // A bubble must not write registers or memory and must not redirect fetch.
    localparam ctrl_t CTRL_BUBBLE = '{
        RegWrite:   1'b0,
        MemWrite:   1'b0,
        Jump:       1'b0,
        Branch:     1'b0,
        ALUSrc:     1'b0,
        ResultSrc:  RES_ALU,
        ALUControl: ALU_ADD
    };

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous active-low clear that sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use stall detection, redirect flush and
// saturating stall/flush event counters.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    input  logic [4:0]       RDD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic             PCSrcE,
    output logic [4:0]       RS1E,
    output logic [4:0]       RS2E,
    output logic [4:0]       RDE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [XLEN-1:0] r_rd1, r_rd2, r_imm, r_pc, r_pc4;
    ctrl_t           r_ctrl;
    ctrl_t           w_ctrlD;
    logic            w_lwStall;
    logic            w_flushE;

    assign w_ctrlD = '{
        RegWrite:   RegWriteD,
        MemWrite:   MemWriteD,
        Jump:       JumpD,
        Branch:     BranchD,
        ALUSrc:     ALUSrcD,
        ResultSrc:  ResultSrcD,
        ALUControl: ALUControlD
    };

    // Only a load sitting in EX can't be forwarded in time; x0 is never a real dependency.
    assign w_lwStall = (r_ctrl.ResultSrc == RES_MEM) && (r_rd != REG_ZERO) &&
                       ((r_rd == RS1D) || (r_rd == RS2D));

    // A taken redirect overrides the stall so the new fetch address isn't held off.
    assign StallF   = w_lwStall && !PCSrcE;
    assign StallD   = w_lwStall && !PCSrcE;
    assign FlushD   = PCSrcE;
    assign w_flushE = w_lwStall || PCSrcE;
    assign FlushE   = w_flushE;

    always_ff @(posedge clk) begin
        if (!reset || w_flushE) begin
            r_rs1  <= REG_ZERO;
            r_rs2  <= REG_ZERO;
            r_rd   <= REG_ZERO;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            r_pc   <= '0;
            r_pc4  <= '0;
            r_ctrl <= CTRL_BUBBLE;
        end else begin
            r_rs1  <= RS1D;
            r_rs2  <= RS2D;
            r_rd   <= RDD;
            r_rd1  <= RD1D;
            r_rd2  <= RD2D;
            r_imm  <= ImmExtD;
            r_pc   <= PCD;
            r_pc4  <= PCPlus4D;
            r_ctrl <= w_ctrlD;
        end
    end

    assign RS1E        = r_rs1;
    assign RS2E        = r_rs2;
    assign RDE         = r_rd;
    assign RD1E        = r_rd1;
    assign RD2E        = r_rd2;
    assign ImmExtE     = r_imm;
    assign PCE         = r_pc;
    assign PCPlus4E    = r_pc4;
    assign RegWriteE   = r_ctrl.RegWrite;
    assign MemWriteE   = r_ctrl.MemWrite;
    assign JumpE       = r_ctrl.Jump;
    assign BranchE     = r_ctrl.Branch;
    assign ALUSrcE     = r_ctrl.ALUSrc;
    assign ResultSrcE  = r_ctrl.ResultSrc;
    assign ALUControlE = r_ctrl.ALUControl;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (StallD),
        .o_count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (PCSrcE),
        .o_count (flush_count)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; a second narrow-counter instance shares
// the stimulus so counter saturation is reachable in a short run.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 32;
    localparam int SMALL_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [4:0]       RS1D, RS2D, RDD;
    logic [XLEN-1:0]  RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic             RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, PCSrcE;
    logic [1:0]       ResultSrcD;
    logic [2:0]       ALUControlD;

    logic [4:0]       RS1E, RS2E, RDE;
    logic [XLEN-1:0]  RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic             RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]       ResultSrcE;
    logic [2:0]       ALUControlE;
    logic             StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] stallCount, flushCount;

    logic [4:0]         sRs1E, sRs2E, sRdE;
    logic [XLEN-1:0]    sRd1E, sRd2E, sImmE, sPcE, sPc4E;
    logic               sRegWriteE, sMemWriteE, sJumpE, sBranchE, sAluSrcE;
    logic [1:0]         sResultSrcE;
    logic [2:0]         sAluControlE;
    logic               sStallF, sStallD, sFlushD, sFlushE;
    logic [SMALL_W-1:0] sStallCount, sFlushCount;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .RS1D(RS1D), .RS2D(RS2D), .RDD(RDD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .PCSrcE(PCSrcE),
        .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .stall_count(stallCount), .flush_count(flushCount)
    );

    id_ex_stage #(.XLEN(XLEN), .CNT_W(SMALL_W)) dutSmall (
        .clk(clk), .reset(reset), .RS1D(RS1D), .RS2D(RS2D), .RDD(RDD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .PCSrcE(PCSrcE),
        .RS1E(sRs1E), .RS2E(sRs2E), .RDE(sRdE), .RD1E(sRd1E), .RD2E(sRd2E), .ImmExtE(sImmE),
        .PCE(sPcE), .PCPlus4E(sPc4E), .RegWriteE(sRegWriteE), .MemWriteE(sMemWriteE),
        .JumpE(sJumpE), .BranchE(sBranchE), .ALUSrcE(sAluSrcE), .ResultSrcE(sResultSrcE),
        .ALUControlE(sAluControlE), .StallF(sStallF), .StallD(sStallD), .FlushD(sFlushD),
        .FlushE(sFlushE), .stall_count(sStallCount), .flush_count(sFlushCount)
    );

    typedef struct {
        logic [4:0]         rs1, rs2, rd;
        logic [XLEN-1:0]    rd1, rd2, imm, pc, pc4;
        logic               rw, mw, j, b, as;
        logic [1:0]         rsrc;
        logic [2:0]         alu;
        logic [CNT_W-1:0]   sc, fc;
        logic [SMALL_W-1:0] scS, fcS;
    } exp_t;

    exp_t model;
    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one decode cycle, check the combinational strobes against the model,
    // push the expected E state and compare it after the edge.
    task automatic applyStimulus(input logic rst, input logic pcsrc,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [1:0] rsrc,
                                 input logic rw);
        logic lw, expStall, expFlushE;
        exp_t nx, got;
        reset       = rst;
        PCSrcE      = pcsrc;
        RS1D        = rs1;
        RS2D        = rs2;
        RDD         = rd;
        ResultSrcD  = rsrc;
        RegWriteD   = rw;
        RD1D        = $urandom;
        RD2D        = $urandom;
        ImmExtD     = $urandom;
        PCD         = $urandom;
        PCPlus4D    = PCD + 32'd4;
        MemWriteD   = 1'($urandom_range(0, 1));
        JumpD       = 1'($urandom_range(0, 1));
        BranchD     = 1'($urandom_range(0, 1));
        ALUSrcD     = 1'($urandom_range(0, 1));
        ALUControlD = 3'($urandom_range(0, 7));
        #1;
        lw        = (model.rsrc == 2'b01) && (model.rd != 5'd0) && ((model.rd == rs1) || (model.rd == rs2));
        expStall  = lw && !pcsrc;
        expFlushE = lw || pcsrc;
        checkOutput("StallF", 64'(StallF), 64'(expStall));
        checkOutput("StallD", 64'(StallD), 64'(expStall));
        checkOutput("FlushD", 64'(FlushD), 64'(pcsrc));
        checkOutput("FlushE", 64'(FlushE), 64'(expFlushE));
        checkOutput("smallStallD", 64'(sStallD), 64'(expStall));

        nx = '{default: '0};
        if (rst) begin
            nx.sc  = model.sc;
            nx.fc  = model.fc;
            nx.scS = model.scS;
            nx.fcS = model.fcS;
            if (!expFlushE) begin
                nx.rs1 = rs1;       nx.rs2 = rs2;   nx.rd = rd;
                nx.rd1 = RD1D;      nx.rd2 = RD2D;  nx.imm = ImmExtD;
                nx.pc  = PCD;       nx.pc4 = PCPlus4D;
                nx.rw  = rw;        nx.mw = MemWriteD; nx.j = JumpD;
                nx.b   = BranchD;   nx.as = ALUSrcD;
                nx.rsrc = rsrc;     nx.alu = ALUControlD;
            end
            if (expStall && nx.sc != '1)  nx.sc  = nx.sc + 1;
            if (pcsrc && nx.fc != '1)     nx.fc  = nx.fc + 1;
            if (expStall && nx.scS != '1) nx.scS = nx.scS + 1;
            if (pcsrc && nx.fcS != '1)    nx.fcS = nx.fcS + 1;
        end
        expQ.push_back(nx);
        model = nx;

        @(posedge clk);
        #1;
        got = expQ.pop_front();
        checkOutput("RS1E", 64'(RS1E), 64'(got.rs1));
        checkOutput("RS2E", 64'(RS2E), 64'(got.rs2));
        checkOutput("RDE", 64'(RDE), 64'(got.rd));
        checkOutput("RD1E", 64'(RD1E), 64'(got.rd1));
        checkOutput("RD2E", 64'(RD2E), 64'(got.rd2));
        checkOutput("ImmExtE", 64'(ImmExtE), 64'(got.imm));
        checkOutput("PCE", 64'(PCE), 64'(got.pc));
        checkOutput("PCPlus4E", 64'(PCPlus4E), 64'(got.pc4));
        checkOutput("ctrlE", 64'({RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE}),
                    64'({got.rw, got.mw, got.j, got.b, got.as, got.rsrc, got.alu}));
        checkOutput("stall_count", 64'(stallCount), 64'(got.sc));
        checkOutput("flush_count", 64'(flushCount), 64'(got.fc));
        checkOutput("smallStallCount", 64'(sStallCount), 64'(got.scS));
        checkOutput("smallFlushCount", 64'(sFlushCount), 64'(got.fcS));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; PCSrcE = 1'b0;
        RS1D = '0; RS2D = '0; RDD = '0; RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0; PCPlus4D = '0;
        RegWriteD = 1'b0; MemWriteD = 1'b0; JumpD = 1'b0; BranchD = 1'b0; ALUSrcD = 1'b0;
        ResultSrcD = 2'b00; ALUControlD = 3'b000;
        model = '{default: '0};
        @(posedge clk);
        @(negedge clk);

        // Second reset cycle with random decode inputs must still yield zeros.
        applyStimulus(1'b0, 1'b0, 5'd9, 5'd10, 5'd11, 2'b01, 1'b1);

        // Plain pass-through.
        applyStimulus(1'b1, 1'b0, 5'd3, 5'd4, 5'd5, 2'b00, 1'b1);
        checkOutput("passRS1E", 64'(RS1E), 64'd3);

        // lw x5 then a reader of x5 on rs2: one stall, then a bubble, then it issues.
        applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 5'd5, 2'b01, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd6, 5'd5, 5'd7, 2'b00, 1'b1);
        checkOutput("bubbleRegWriteE", 64'(RegWriteE), 64'd0);
        checkOutput("stallCountOne", 64'(stallCount), 64'd1);
        applyStimulus(1'b1, 1'b0, 5'd6, 5'd5, 5'd7, 2'b00, 1'b1);

        // lw x0 followed by a reader of x0 never stalls.
        applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 2'b01, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd8, 2'b00, 1'b1);

        // Taken branch flushes D and E.
        applyStimulus(1'b1, 1'b1, 5'd12, 5'd13, 5'd14, 2'b00, 1'b1);
        checkOutput("flushCountOne", 64'(flushCount), 64'd1);

        // Load-use and redirect in the same cycle: flush wins.
        applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 5'd7, 2'b01, 1'b1);
        applyStimulus(1'b1, 1'b1, 5'd7, 5'd3, 5'd9, 2'b00, 1'b1);

        // Back-to-back dependent loads.
        applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 5'd6, 2'b01, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd6, 5'd0, 5'd7, 2'b01, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd6, 5'd0, 5'd7, 2'b01, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd7, 5'd7, 5'd8, 2'b00, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd7, 5'd7, 5'd8, 2'b00, 1'b1);

        // Reset during a stall clears E so the stall drops next cycle.
        applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 5'd8, 2'b01, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd8, 5'd2, 5'd9, 2'b00, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd8, 5'd2, 5'd9, 2'b00, 1'b1);

        // Drive the narrow counters into saturation.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 2'b00, 1'b1);
        end
        checkOutput("flushSaturated", 64'(sFlushCount), 64'hF);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 5'd4, 2'b01, 1'b1);
            applyStimulus(1'b1, 1'b0, 5'd4, 5'd2, 5'd5, 2'b00, 1'b1);
        end
        checkOutput("stallSaturated", 64'(sStallCount), 64'hF);

        // Random traffic over a small register window to hit many hazards.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 5) == 0),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
